// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detector gradient stage.
package edge_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD       = 2'd1,
      PROCESSING = 2'd2
   } sobel_state_t;

   // Quantised gradient direction codes
   localparam logic [1:0] DIR_0   = 2'd0;
   localparam logic [1:0] DIR_45  = 2'd1;
   localparam logic [1:0] DIR_90  = 2'd2;
   localparam logic [1:0] DIR_135 = 2'd3;

   localparam int NUM_ROWS   = 16;
   localparam int COLS       = 3;
   localparam int OUT_ROWS   = 14;
   localparam int LAST_INDEX = 6;

   // 3x3 neighbourhood indexed [row][col]; row 0 = top, col 0 = left
   typedef logic [2:0][2:0][7:0] pix3x3_t;

   function automatic logic [10:0] abs11(input logic signed [10:0] v);
      return v[10] ? 11'(-v) : 11'(v);
   endfunction

endpackage

// File: rtl/sobel_controller_if.sv
// Column-in / gradient-out bundle between blur, sobel and NMS stages.
// Handshake: there is no backpressure. A rising edge on blur_final offers a
// new column on blur_in (held stable until it is loaded); sobel_valid is a
// one-cycle pulse marking mag_out/dir_out as a coherent new column.
interface sobel_controller_if;
   import edge_pkg::*;

   logic [31:0]                anchor_x;
   logic                       blur_final;
   logic [NUM_ROWS-1:0][7:0]   blur_in;
   logic [OUT_ROWS-1:0][7:0]   mag_out;
   logic [OUT_ROWS-1:0][1:0]   dir_out;
   logic                       sobel_final;
   logic                       sobel_valid;
   logic                       overrun;
   sobel_state_t               dbg_state;
   logic                       dbg_pending;
   logic [2:0]                 dbg_index;

   modport slave (
      input  anchor_x, blur_final, blur_in,
      output mag_out, dir_out, sobel_final, sobel_valid, overrun,
             dbg_state, dbg_pending, dbg_index
   );

   modport master (
      output anchor_x, blur_final, blur_in,
      input  mag_out, dir_out, sobel_final, sobel_valid, overrun,
             dbg_state, dbg_pending, dbg_index
   );

endinterface

// File: rtl/sobel_unit.sv
// Combinational 3x3 Sobel: magnitude (|gx|+|gy|)>>MAG_SHIFT and 4-way direction.
module sobel_unit
   import edge_pkg::*;
#(
   parameter int MAG_SHIFT = 3
) (
   input  pix3x3_t    pix_i,
   output logic [7:0] mag_o,
   output logic [1:0] dir_o
);

   logic signed [10:0] gx, gy;
   logic [10:0]        ax, ay;
   logic [11:0]        sum;
   logic [12:0]        ax5, ay5, ax2, ay2;

   function automatic logic signed [10:0] wsum(input logic [7:0] a, b, c);
      return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
   endfunction

   // Gradients, magnitude and direction sector
   always_comb begin
      gx    = wsum(pix_i[0][2], pix_i[1][2], pix_i[2][2]) -
              wsum(pix_i[0][0], pix_i[1][0], pix_i[2][0]);
      gy    = wsum(pix_i[2][0], pix_i[2][1], pix_i[2][2]) -
              wsum(pix_i[0][0], pix_i[0][1], pix_i[0][2]);
      ax    = abs11(gx);
      ay    = abs11(gy);
      sum   = {1'b0, ax} + {1'b0, ay};
      mag_o = 8'(sum >> MAG_SHIFT);
      ax5   = 13'(ax) * 13'd5;
      ay5   = 13'(ay) * 13'd5;
      ax2   = 13'(ax) << 1;
      ay2   = 13'(ay) << 1;
      dir_o = DIR_0;
      if (ax == 11'd0 && ay == 11'd0) dir_o = DIR_0;
      else if (ay5 < ax2)             dir_o = DIR_0;
      else if (ax5 < ay2)             dir_o = DIR_90;
      else if (gx[10] == gy[10])      dir_o = DIR_45;
      else                            dir_o = DIR_135;
   end

endmodule

// File: rtl/sobel_controller.sv
// Gradient stage: shifts blurred columns into a 3-column window and computes
// Sobel magnitude/direction for rows 1..14 of the centre column, two rows per cycle.
module sobel_controller
   import edge_pkg::*;
#(
   parameter int MAG_SHIFT = 3
) (
   input logic                clk,
   input logic                n_rst,
   sobel_controller_if.slave  bus
);

   sobel_state_t                         state_q, state_d;
   logic [2:0]                           index_q, index_d;
   logic                                 pending_q, pending_d;
   logic                                 overrun_q, overrun_d;
   logic                                 valid_q, valid_d;
   logic                                 blur_final_q;
   logic [COLS-1:0][NUM_ROWS-1:0][7:0]   win_q;
   logic [OUT_ROWS-1:0][7:0]             mag_q;
   logic [OUT_ROWS-1:0][1:0]             dir_q;
   logic                                 col_ready;
   logic [3:0]                           row_a;
   pix3x3_t                              pix_a, pix_b;
   logic [7:0]                           mag_a, mag_b;
   logic [1:0]                           dir_a, dir_b;

   assign col_ready = bus.blur_final & ~blur_final_q;
   assign row_a     = {index_q, 1'b0};

   // Control state registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         index_q      <= 3'd0;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         valid_q      <= 1'b0;
         blur_final_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         valid_q      <= valid_d;
         blur_final_q <= bus.blur_final;
      end
   end

   // Next state, row index, pending/overrun bookkeeping
   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      valid_d   = 1'b0;
      case (state_q)
         IDLE: if (col_ready) state_d = LOAD;
         LOAD: begin
            state_d = PROCESSING;
            index_d = 3'd0;
         end
         PROCESSING: begin
            if (index_q == 3'(LAST_INDEX)) begin
               valid_d = 1'b1;
               index_d = 3'd0;
               state_d = (pending_q || col_ready) ? LOAD : IDLE;
            end else begin
               index_d = index_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Entering LOAD consumes the pending column; index-6 col_ready goes straight there
      pending_d = pending_q;
      if (state_d == LOAD && state_q != LOAD) pending_d = 1'b0;
      else if (col_ready && state_q != IDLE)  pending_d = 1'b1;
      overrun_d = overrun_q | (col_ready & pending_q);
   end

   // Gather the two 3x3 neighbourhoods for rows 2i+1 and 2i+2
   always_comb begin
      pix_a = '0;
      pix_b = '0;
      for (int rr = 0; rr < 3; rr++) begin
         for (int cc = 0; cc < 3; cc++) begin
            pix_a[rr][cc] = win_q[2'(2 - cc)][row_a + 4'(rr)];
            pix_b[rr][cc] = win_q[2'(2 - cc)][row_a + 4'(rr + 1)];
         end
      end
   end

   sobel_unit #(.MAG_SHIFT(MAG_SHIFT)) u_sobel_a (.pix_i(pix_a), .mag_o(mag_a), .dir_o(dir_a));
   sobel_unit #(.MAG_SHIFT(MAG_SHIFT)) u_sobel_b (.pix_i(pix_b), .mag_o(mag_b), .dir_o(dir_b));

   // Window shift on LOAD; progressive result write-back during PROCESSING
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         win_q <= '0;
         mag_q <= '0;
         dir_q <= '0;
      end else begin
         if (state_q == LOAD) begin
            if (bus.anchor_x == 32'd0) begin
               win_q <= {bus.blur_in, bus.blur_in, bus.blur_in};
            end else begin
               win_q[2] <= win_q[1];
               win_q[1] <= win_q[0];
               win_q[0] <= bus.blur_in;
            end
         end
         if (state_q == PROCESSING) begin
            mag_q[row_a]        <= mag_a;
            mag_q[row_a + 4'd1] <= mag_b;
            dir_q[row_a]        <= dir_a;
            dir_q[row_a + 4'd1] <= dir_b;
         end
      end
   end

   assign bus.mag_out     = mag_q;
   assign bus.dir_out     = dir_q;
   assign bus.sobel_final = (state_q == IDLE);
   assign bus.sobel_valid = valid_q;
   assign bus.overrun     = overrun_q;
   assign bus.dbg_state   = state_q;
   assign bus.dbg_pending = pending_q;
   assign bus.dbg_index   = index_q;

endmodule

// File: tb/tb_sobel_controller.sv
// Bench for sobel_controller: directed columns with hand-computed gradients,
// expected columns queued at issue and checked by an output monitor.
module tb_sobel_controller;
   import edge_pkg::*;

   localparam int W = 14 * 8 + 14 * 2;

   logic clk;
   logic n_rst;
   int   cyc;
   int   checks;
   int   errors;
   int   t_edge;
   int   vcyc[$];

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w;
   logic [W-1:0] act_w;

   logic [13:0][7:0] em;
   logic [13:0][1:0] ed;

   sobel_controller_if ifc ();

   sobel_controller #(.MAG_SHIFT(3)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (ifc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (n_rst && ifc.sobel_valid) begin
         vcyc.push_back(cyc);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: got sobel_valid=1 expected no output (cycle %0d)", cyc);
         end else begin
            exp_w = exp_q.pop_front();
            act_w = {ifc.mag_out, ifc.dir_out};
            if (act_w !== exp_w) begin
               errors++;
               $display("FAIL column: got %h expected %h", act_w, exp_w);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0][7:0] col_fill(input logic [7:0] v);
      logic [15:0][7:0] c;
      for (int i = 0; i < 16; i++) c[i] = v;
      return c;
   endfunction

   function automatic logic [15:0][7:0] col_hstep();
      logic [15:0][7:0] c;
      for (int i = 0; i < 16; i++) c[i] = (i < 8) ? 8'd0 : 8'd80;
      return c;
   endfunction

   // driver tasks
   task automatic send_col(input logic [31:0] ax, input logic [15:0][7:0] col);
      @(posedge clk); #1;
      ifc.anchor_x   = ax;
      ifc.blur_in    = col;
      ifc.blur_final = 1'b1;
      t_edge         = cyc;
      @(posedge clk); #1;
      ifc.blur_final = 1'b0;
   endtask

   task automatic pulse_final();
      ifc.blur_final = 1'b1;
      @(posedge clk); #1;
      ifc.blur_final = 1'b0;
   endtask

   task automatic wait_index(input logic [2:0] idx);
      int n = 0;
      while (!(ifc.dbg_state == PROCESSING && ifc.dbg_index == idx) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("wait_index", 64'(n < 50), 64'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_q.size() != 0 || ifc.dbg_state != IDLE) && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("wait_done", 64'(n < 300), 64'd1);
   endtask

   task automatic push_exp();
      exp_q.push_back({em, ed});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      n_rst  = 1'b0;
      ifc.anchor_x   = 32'd0;
      ifc.blur_final = 1'b0;
      ifc.blur_in    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", 64'(ifc.dbg_state), 64'(IDLE));
      chk("rst_sobel_final", 64'(ifc.sobel_final), 64'd1);
      chk("rst_valid", 64'(ifc.sobel_valid), 64'd0);
      chk("rst_overrun", 64'(ifc.overrun), 64'd0);
      chk("rst_outputs_zero", 64'({ifc.mag_out, ifc.dir_out} == '0), 64'd1);
      @(posedge clk); #1;
      n_rst = 1'b1;

      // uniform 100: all zero, latency 9
      em = '0; ed = '0;
      vcyc.delete();
      push_exp(); send_col(32'd0, col_fill(8'd100)); wait_done();
      chk("latency", 64'(vcyc.size() > 0 ? vcyc[0] - t_edge : -1), 64'd9);
      push_exp(); send_col(32'd1, col_fill(8'd100)); wait_done();
      push_exp(); send_col(32'd2, col_fill(8'd100)); wait_done();

      // vertical step: right column 200, others 0 -> mag 100, dir 0
      push_exp(); send_col(32'd0, col_fill(8'd0)); wait_done();
      push_exp(); send_col(32'd1, col_fill(8'd0)); wait_done();
      for (int k = 0; k < 14; k++) begin em[k] = 8'd100; ed[k] = DIR_0; end
      push_exp(); send_col(32'd2, col_fill(8'd200)); wait_done();

      // horizontal step, then right column all 80 (diagonal 45)
      em = '0; ed = '0;
      em[6] = 8'd40; ed[6] = DIR_90;
      em[7] = 8'd40; ed[7] = DIR_90;
      push_exp(); send_col(32'd0, col_hstep()); wait_done();
      em = '0; ed = '0;
      for (int k = 0; k < 6; k++) em[k] = 8'd40;
      em[6] = 8'd60; ed[6] = DIR_45;
      em[7] = 8'd40; ed[7] = DIR_90;
      push_exp(); send_col(32'd1, col_fill(8'd80)); wait_done();

      // horizontal step, then right column all 0 (diagonal 135)
      em = '0; ed = '0;
      em[6] = 8'd40; ed[6] = DIR_90;
      em[7] = 8'd40; ed[7] = DIR_90;
      push_exp(); send_col(32'd0, col_hstep()); wait_done();
      em = '0; ed = '0;
      em[6] = 8'd40; ed[6] = DIR_90;
      em[7] = 8'd60; ed[7] = DIR_135;
      for (int k = 8; k < 14; k++) em[k] = 8'd40;
      push_exp(); send_col(32'd1, col_fill(8'd0)); wait_done();

      // reset during PROCESSING index 4: column discarded
      send_col(32'd0, col_fill(8'd100));
      wait_index(3'd4);
      n_rst = 1'b0;
      @(negedge clk);
      chk("midrst_state", 64'(ifc.dbg_state), 64'(IDLE));
      chk("midrst_sobel_final", 64'(ifc.sobel_final), 64'd1);
      chk("midrst_outputs_zero", 64'({ifc.mag_out, ifc.dir_out} == '0), 64'd1);
      chk("midrst_pending", 64'(ifc.dbg_pending), 64'd0);
      chk("midrst_valid", 64'(ifc.sobel_valid), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;

      // back-to-back: second edge at index 3
      vcyc.delete();
      em = '0; ed = '0;
      push_exp();
      for (int k = 0; k < 14; k++) em[k] = 8'd50;
      push_exp();
      send_col(32'd0, col_fill(8'd100));
      wait_index(3'd3);
      ifc.anchor_x = 32'd1;
      ifc.blur_in  = col_fill(8'd200);
      pulse_final();
      chk("b2b_pending", 64'(ifc.dbg_pending), 64'd1);
      wait_done();
      chk("b2b_two_pulses", 64'(vcyc.size()), 64'd2);
      chk("b2b_spacing", 64'(vcyc.size() == 2 ? vcyc[1] - vcyc[0] : -1), 64'd8);
      chk("b2b_overrun", 64'(ifc.overrun), 64'd0);

      // overrun: three edges in one pass, third column dropped
      em = '0; ed = '0;
      push_exp(); push_exp();
      send_col(32'd0, col_fill(8'd50));
      wait_index(3'd1);
      ifc.anchor_x = 32'd1;
      pulse_final();
      wait_index(3'd3);
      pulse_final();
      chk("ovr_pending", 64'(ifc.dbg_pending), 64'd1);
      chk("ovr_set", 64'(ifc.overrun), 64'd1);
      wait_done();
      repeat (20) @(posedge clk);
      #1;
      chk("ovr_sticky", 64'(ifc.overrun), 64'd1);
      chk("ovr_idle", 64'(ifc.sobel_final), 64'd1);

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
